// File: rtl/post_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : post_proc_pkg
// Description : Shared constants, types and helpers for the post_proc stream
//               blocks (coordinate width, window index type, ceil-log2).
// Revision    : 1.0 - initial release
// ============================================================================
package post_proc_pkg;

    // Width of the pixel column/row coordinates carried alongside the stream.
    localparam int c_coord_w = 10;

    // Flattened window index; wide enough for the largest 7x7 window.
    typedef logic [5:0] win_idx_t;

    // Number of bits needed to hold the values 0..n-1 (minimum 0).
    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rank_select.sv
`default_nettype none
// ============================================================================
// Module      : rank_select
// Description : Three-stage rank-select pipeline. S1 forms all pairwise
//               "less than" bits, S2 sums them into unique ranks, S3 picks
//               the pixel whose rank equals MED (or the centre pixel when
//               bypass is set). Outputs hold between valid pulses.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_win[N]          - flattened window, index 0 oldest
//               i_centre          - window centre pixel
//               i_bypass          - select centre instead of median
//               i_valid           - window is complete and inside the frame
//               i_x, i_y          - centre coordinates
//               o_pix, o_x, o_y   - selected pixel and its coordinates
//               o_valid           - one-cycle result strobe
// Revision    : 1.0 - initial release
// ============================================================================
module rank_select
    import post_proc_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int N     = 9,
    parameter int MED   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     i_win [N],
    input  logic [PIX_W-1:0]     i_centre,
    input  logic                 i_bypass,
    input  logic                 i_valid,
    input  logic [c_coord_w-1:0] i_x,
    input  logic [c_coord_w-1:0] i_y,
    output logic [PIX_W-1:0]     o_pix,
    output logic [c_coord_w-1:0] o_x,
    output logic [c_coord_w-1:0] o_y,
    output logic                 o_valid
);

    localparam int c_rank_w = CLOG2(N);

    // S1 registers
    logic [N-1:0]         r1_lt  [N];
    logic [PIX_W-1:0]     r1_pix [N];
    logic [PIX_W-1:0]     r1_centre;
    logic                 r1_byp;
    logic [c_coord_w-1:0] r1_x, r1_y;
    logic                 r1_valid;

    // S2 registers
    logic [c_rank_w-1:0]  r2_rank [N];
    logic [PIX_W-1:0]     r2_pix  [N];
    logic [PIX_W-1:0]     r2_centre;
    logic                 r2_byp;
    logic [c_coord_w-1:0] r2_x, r2_y;
    logic                 r2_valid;

    logic [N-1:0]         w_lt   [N];
    logic [c_rank_w-1:0]  w_rank [N];
    logic [PIX_W-1:0]     w_med;

    // Equal values are ordered by index so every rank is distinct and
    // exactly one entry lands on MED even with ties.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_lt[i] = '0;
            for (int j = 0; j < N; j++) begin
                w_lt[i][j] = (i_win[j] < i_win[i]) ||
                             ((i_win[j] == i_win[i]) && (j < i));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < N; j++) begin
                w_rank[i] = w_rank[i] + c_rank_w'(r1_lt[i][j]);
            end
        end
    end

    always_comb begin
        w_med = '0;
        for (int i = 0; i < N; i++) begin
            if (r2_rank[i] == c_rank_w'(MED)) begin
                w_med = r2_pix[i];
            end
        end
    end

    // Data path stages: no reset needed, qualified by the valid chain.
    always_ff @(posedge clk) begin
        r1_lt     <= w_lt;
        r1_pix    <= i_win;
        r1_centre <= i_centre;
        r1_byp    <= i_bypass;
        r1_x      <= i_x;
        r1_y      <= i_y;

        r2_rank   <= w_rank;
        r2_pix    <= r1_pix;
        r2_centre <= r1_centre;
        r2_byp    <= r1_byp;
        r2_x      <= r1_x;
        r2_y      <= r1_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_pix    <= '0;
            o_x      <= '0;
            o_y      <= '0;
        end else begin
            r1_valid <= i_valid;
            r2_valid <= r1_valid;
            o_valid  <= r2_valid;
            if (r2_valid) begin
                o_pix <= r2_byp ? r2_centre : w_med;
                o_x   <= r2_x;
                o_y   <= r2_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg
// Description : Enable-gated delay line of DEPTH words, used as a line buffer.
//               Contents are never reset; o_q is the word that entered DEPTH
//               enabled shifts ago.
// Ports       : clk  - system clock
//               i_en - shift enable
//               i_d  - word entering the line
//               o_q  - oldest word in the line
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_mem[k] <= r_mem[k-1];
            end
        end
    end

    assign o_q = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/median_filt_rank.sv
`default_nettype none
// ============================================================================
// Module      : median_filt_rank
// Description : Streaming WNDW_SZ x WNDW_SZ median filter with runtime
//               bypass. Raster-order pixels fill a register window chained
//               through line buffers; a result is emitted for every interior
//               window centre once a frame start (0,0) has been seen.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               in_val, in_x, in_y    - input pixel and its coordinates
//               is_in_val             - input pixel strobe
//               bypass                - emit centre pixel instead of median
//               out_val, out_x, out_y - filtered pixel at window centre
//               is_out_val            - output strobe, one cycle per result
// Revision    : 1.0 - initial release
// ============================================================================
module median_filt_rank
    import post_proc_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int WNDW_SZ = 3,
    parameter int ROW_SZ  = 320,
    parameter int COL_SZ  = 240
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     in_val,
    input  logic [c_coord_w-1:0] in_x,
    input  logic [c_coord_w-1:0] in_y,
    input  logic                 is_in_val,
    input  logic                 bypass,
    output logic [PIX_W-1:0]     out_val,
    output logic [c_coord_w-1:0] out_x,
    output logic [c_coord_w-1:0] out_y,
    output logic                 is_out_val
);

    localparam int c_r        = WNDW_SZ / 2;
    localparam int c_n        = WNDW_SZ * WNDW_SZ;
    localparam int c_med      = (c_n - 1) / 2;
    localparam int c_lb_depth = ROW_SZ - WNDW_SZ;

    localparam logic [c_coord_w-1:0] c_edge    = c_coord_w'(2 * c_r);
    localparam logic [c_coord_w-1:0] c_rofs    = c_coord_w'(c_r);
    localparam logic [c_coord_w-1:0] c_row_lim = c_coord_w'(ROW_SZ);
    localparam logic [c_coord_w-1:0] c_col_lim = c_coord_w'(COL_SZ);

    // r_win[r][c]: r = 0 oldest row, c = 0 oldest column.
    logic [PIX_W-1:0]     r_win  [WNDW_SZ][WNDW_SZ];
    logic [PIX_W-1:0]     w_lb_q [WNDW_SZ-1];
    logic [PIX_W-1:0]     w_flat [c_n];

    logic                 w_shift;
    logic                 w_frame_start;
    logic                 w_ok;

    logic                 r_sync;
    logic                 r_win_ok;
    logic                 r_byp;
    logic [c_coord_w-1:0] r_cx;
    logic [c_coord_w-1:0] r_cy;

    // A pixel that coincides with reset is dropped entirely.
    assign w_shift       = is_in_val & ~reset;
    assign w_frame_start = (in_x == '0) && (in_y == '0);

    // Coordinate-driven validity: the window must lie wholly inside the
    // frame, and the stream must have been aligned by a (0,0) pixel so no
    // pre-reset line-buffer contents leak into a result.
    assign w_ok = (r_sync | w_frame_start) &
                  (in_x >= c_edge) & (in_y >= c_edge) &
                  (in_x < c_row_lim) & (in_y < c_col_lim);

    // Each row's oldest register feeds a line buffer whose output enters the
    // newest column of the row above; W registers + line buffer = one row.
    for (genvar gr = 0; gr < WNDW_SZ - 1; gr++) begin : g_lb
        shift_reg #(
            .WIDTH (PIX_W),
            .DEPTH (c_lb_depth)
        ) u_lb (
            .clk  (clk),
            .i_en (w_shift),
            .i_d  (r_win[gr+1][0]),
            .o_q  (w_lb_q[gr])
        );
    end

    for (genvar gr = 0; gr < WNDW_SZ; gr++) begin : g_flat_row
        for (genvar gc = 0; gc < WNDW_SZ; gc++) begin : g_flat_col
            assign w_flat[gr*WNDW_SZ + gc] = r_win[gr][gc];
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            for (int r = 0; r < WNDW_SZ; r++) begin
                for (int c = 0; c < WNDW_SZ - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            for (int r = 0; r < WNDW_SZ - 1; r++) begin
                r_win[r][WNDW_SZ-1] <= w_lb_q[r];
            end
            r_win[WNDW_SZ-1][WNDW_SZ-1] <= in_val;
        end
    end

    // Side-band captured alongside the window shift so it lines up with the
    // window contents entering the rank pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= 1'b0;
            r_win_ok <= 1'b0;
            r_byp    <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_win_ok <= is_in_val & w_ok;
            if (is_in_val) begin
                if (w_frame_start) begin
                    r_sync <= 1'b1;
                end
                r_byp <= bypass;
                r_cx  <= in_x - c_rofs;
                r_cy  <= in_y - c_rofs;
            end
        end
    end

    rank_select #(
        .PIX_W (PIX_W),
        .N     (c_n),
        .MED   (c_med)
    ) u_rank_select (
        .clk      (clk),
        .rst      (reset),
        .i_win    (w_flat),
        .i_centre (r_win[c_r][c_r]),
        .i_bypass (r_byp),
        .i_valid  (r_win_ok),
        .i_x      (r_cx),
        .i_y      (r_cy),
        .o_pix    (out_val),
        .o_x      (out_x),
        .o_y      (out_y),
        .o_valid  (is_out_val)
    );

endmodule
`default_nettype wire
